pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central pipeline controller that drives the load and bubble/flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Arbitrates four hazard sources: instruction-memory wait, data-memory wait, multicycle-multiply wait, and load-use.
- Sequences branch-mispredict redirects. When an instruction fetch is still outstanding, it holds the redirect target until that fetch drains.
- Keeps stall and redirect performance counters.

Parameters:
CNT_W, 32, width of the performance counters (wrap-around)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  in  1  fetch request outstanding
imem_resp  in  1  fetch response valid this cycle
dmem_req  in  1  MEM-stage load/store request outstanding
dmem_resp  in  1  data response valid this cycle
ex_mul_active  in  1  EX-stage instruction is a multiply in progress
ex_mul_done  in  1  multiplier result valid this cycle
ex_mem_read  in  1  EX-stage instruction is a load
ex_rd  in  5  EX-stage destination register
id_rs1, id_rs2  in  5 each  ID-stage source registers
id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2
ex_mispredict  in  1  EX resolved a mispredicted branch/jump (single-cycle pulse)
ex_target  in  32  correct PC for ex_mispredict
load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage-register load enables
flush_if_id  out  1  IF/ID captures a NOP instead of the fetched word
bubble_id_ex, bubble_ex_mem  out  1 each  stage register captures an all-zero control word
redirect_valid  out  1  PC mux selects redirect_target this cycle
redirect_target  out  32  redirect PC
stall_cnt, redirect_cnt  out  CNT_W each  performance counters

Behaviour:
Reset:
- While rst is high: state=RUN, drained=0, held_target=0, counters=0.
- All combinational outputs are forced to 0 while rst is high.

Derived signals:
- imem_wait = imem_req & ~imem_resp
- dmem_wait = dmem_req & ~dmem_resp
- mul_wait = ex_mul_active & ~ex_mul_done
- lu_hazard = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))

Outputs are combinational from state and inputs. Priority is highest first:
1. dmem_wait: all load_* = 0, all flush/bubble = 0 (full freeze). No state change, except that drained is set if imem_resp arrives while in REDIR_WAIT.
2. mul_wait: load_mem_wb=1, load_ex_mem=1, bubble_ex_mem=1; load_pc, load_if_id, load_id_ex = 0.
3. State RUN with ex_mispredict: flush_if_id=1, bubble_id_ex=1, all loads=1.
   - If imem_wait: load_pc=0, held_target<=ex_target, next state REDIR_WAIT.
   - Otherwise: redirect_valid=1, redirect_target=ex_target, redirect_cnt increments.
4. State REDIR_WAIT: flush_if_id=1; downstream loads=1; load_pc=0 until the fetch completes.
   - Completion is (imem_req & imem_resp) | drained.
   - On completion: load_pc=1, redirect_valid=1, redirect_target=held_target, redirect_cnt increments, drained<=0, next state RUN.
5. imem_wait, not a redirect case: load_pc=0, load_if_id=1 with flush_if_id=1, all downstream loads=1.
6. lu_hazard: load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, EX/MEM and MEM/WB loads=1.
7. Otherwise: all loads=1, no flush, no bubble.

Counters and sequencing:
- stall_cnt increments on every cycle with load_pc=0 outside reset, wrapping at 2^CNT_W.
- ex_mispredict in REDIR_WAIT is ignored; ID/EX is bubbled, so a second mispredict is illegal and the bench asserts on it.
- Latency: redirect_valid is asserted the same cycle as ex_mispredict, or the cycle the outstanding fetch completes.
- Asserting rst mid-REDIR_WAIT discards held_target; no redirect is issued.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> load_pc=0, load_if_id=0, bubble_id_ex=1, stall_cnt +1; with ex_rd=0 -> no stall.
2. dmem_req held 3 cycles, dmem_resp on cycle 3 -> all loads 0 for 2 cycles, then all 1; stall_cnt=2.
3. Mispredict with no fetch outstanding, ex_target=0x0000_0400 -> same cycle redirect_valid=1, target 0x400, flush_if_id=1, bubble_id_ex=1, redirect_cnt=1.
4. Mispredict while imem_wait, target 0x800, imem_resp 2 cycles later -> REDIR_WAIT; load_pc=0 then redirect_valid=1, target 0x800 on the response cycle; stale word flushed.
5. In REDIR_WAIT, dmem_wait overlaps imem_resp arrival -> drained set; redirect to the held target on the first cycle dmem_wait drops.
6. Multiply: ex_mul_active=1 for 4 cycles, done on 4th -> bubble_ex_mem=1, upstream frozen for 3 cycles; rst pulse mid-REDIR_WAIT -> state RUN, counters 0, no redirect.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central stall/flush controller for a five-stage pipeline. It arbitrates four
// hazard sources: instruction-memory wait, data-memory wait, multicycle-multiply
// wait and load-use. It also sequences branch-mispredict redirects, and keeps
// stall/redirect performance counters.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   imem_req/imem_resp            fetch outstanding / fetch response valid
//   dmem_req/dmem_resp            MEM-stage access outstanding / data response valid
//   ex_mul_active/ex_mul_done     EX multiply in progress / result valid
//   ex_mem_read, ex_rd            EX instruction is a load, its destination
//   id_rs1/id_rs2, id_uses_rs1/2  ID source registers and their use flags
//   ex_mispredict, ex_target      EX mispredict pulse and the correct PC
//   load_*                        stage-register load enables (PC .. MEM/WB)
//   flush_if_id                   IF/ID captures a NOP
//   bubble_id_ex, bubble_ex_mem   stage register captures a zero control word
//   redirect_valid/target         PC mux selects redirect_target
//   stall_cnt, redirect_cnt       wrap-around performance counters
module pipeline_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_mul_active,
    input  logic             ex_mul_done,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_target,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             redirect_valid,
    output logic [31:0]      redirect_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        drained, drained_nxt;
    logic [31:0] held_target, held_target_nxt;

    logic imem_wait, dmem_wait, mul_wait, lu_hazard, fetch_done;

    assign imem_wait  = imem_req & ~imem_resp;
    assign dmem_wait  = dmem_req & ~dmem_resp;
    assign mul_wait   = ex_mul_active & ~ex_mul_done;
    assign lu_hazard  = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));
    // The redirect may go out once the stale fetch responds now, or has
    // already responded during a data-memory freeze (drained).
    assign fetch_done = (imem_req & imem_resp) | drained;

    always_comb begin
        // NOTE: every output and next-state term gets a default before the
        // priority chain, so no path leaves a signal unassigned (no latches).
        load_pc         = 1'b0;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        flush_if_id     = 1'b0;
        bubble_id_ex    = 1'b0;
        bubble_ex_mem   = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        state_nxt       = state;
        drained_nxt     = drained;
        held_target_nxt = held_target;

        if (rst) begin
            // Outputs stay at their zero defaults while in reset.
        end else if (dmem_wait) begin
            // Full freeze; only remember a fetch response that lands meanwhile.
            if (state == REDIR_WAIT && imem_resp)
                drained_nxt = 1'b1;
        end else if (mul_wait) begin
            // Let older instructions retire; EX/MEM takes a bubble.
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (state == RUN && ex_mispredict) begin
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            if (imem_wait) begin
                // Fetch still in flight: park the target until it drains.
                held_target_nxt = ex_target;
                state_nxt       = REDIR_WAIT;
            end else begin
                load_pc         = 1'b1;
                redirect_valid  = 1'b1;
                redirect_target = ex_target;
            end
        end else if (state == REDIR_WAIT) begin
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = 1'b1;
            if (fetch_done) begin
                load_pc         = 1'b1;
                redirect_valid  = 1'b1;
                redirect_target = held_target;
                drained_nxt     = 1'b0;
                state_nxt       = RUN;
            end
        end else if (imem_wait) begin
            load_if_id  = 1'b1;
            flush_if_id = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end else if (lu_hazard) begin
            load_id_ex   = 1'b1;
            bubble_id_ex = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            drained      <= 1'b0;
            held_target  <= 32'd0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            state       <= state_nxt;
            drained     <= drained_nxt;
            held_target <= held_target_nxt;
            if (!load_pc)
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect_valid)
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule
